// File: rtl/branch_target_unit.sv
// ---------------------------------------------------------------------------
// branch_target_unit
//   Computes branch/jump targets and return addresses, then buffers each
//   accepted result in a small FIFO. The head entry is presented downstream
//   through a valid/ready handshake.
//
// Parameters
//   XLEN  : address/data width (32 or 64)
//   DEPTH : output queue entries (1..8)
//
// Ports
//   clk, rst_n         : rising-edge clock, asynchronous active-low reset
//   flush              : synchronous queue clear; drops any concurrent request
//   in_valid/in_ready  : request handshake
//   mode               : 00 BRANCH, 01 JAL, 10 JALR, 11 SEQ
//   current_PC, imm_value, rs1_value : operands
//   out_valid/out_ready: head-of-queue handshake
//   branch_PC, link_PC : head target / return address (0 when queue empty)
//   misaligned         : head target alignment fault (0 when queue empty)
//
// Configuration
//   BTU_RVC_EN defined   : 2-byte target alignment (only bit 0 must be clear)
//   BTU_RVC_EN undefined : 4-byte target alignment (bits [1:0] must be clear)
// ---------------------------------------------------------------------------
module branch_target_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      mode,
    input  logic [XLEN-1:0] current_PC,
    input  logic [XLEN-1:0] imm_value,
    input  logic [XLEN-1:0] rs1_value,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] branch_PC,
    output logic [XLEN-1:0] link_PC,
    output logic            misaligned
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        MODE_BRANCH = 2'b00,
        MODE_JAL    = 2'b01,
        MODE_JALR   = 2'b10,
        MODE_SEQ    = 2'b11
    } mode_e;

    mode_e            mode_dec;
    logic [XLEN-1:0]  pc_imm_sum;
    logic [XLEN-1:0]  rs1_imm_sum;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  target;
    logic             target_misaligned;

    logic [XLEN-1:0]  mem_target [DEPTH];
    logic [XLEN-1:0]  mem_link   [DEPTH];
    logic             mem_mis    [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [15:0]      accept_cnt;

    logic             handshake_in;
    logic             push;
    logic             pop;

    // -----------------------------------------------------------------------
    // Target computation (all sums wrap modulo 2^XLEN)
    // -----------------------------------------------------------------------
    assign mode_dec    = mode_e'(mode);
    assign pc_imm_sum  = current_PC + imm_value;
    assign rs1_imm_sum = rs1_value + imm_value;
    assign seq_pc      = current_PC + XLEN'(4);

    always_comb begin
        target = pc_imm_sum;
        case (mode_dec)
            MODE_BRANCH: target = pc_imm_sum;
            MODE_JAL:    target = pc_imm_sum;
            MODE_JALR:   target = {rs1_imm_sum[XLEN-1:1], 1'b0};
            MODE_SEQ:    target = seq_pc;
            default:     target = pc_imm_sum;
        endcase
    end

`ifdef BTU_RVC_EN
    assign target_misaligned = target[0];
`else
    assign target_misaligned = |target[1:0];
`endif

    // -----------------------------------------------------------------------
    // Handshake. A full queue still accepts when the head is leaving in the
    // same cycle. flush does not gate in_ready; it only discards the push.
    // -----------------------------------------------------------------------
    assign out_valid    = (count != '0);
    assign in_ready     = (count < CNT_W'(DEPTH)) || out_ready;
    assign handshake_in = in_valid && in_ready;
    assign push         = handshake_in && !flush;
    assign pop          = out_valid && out_ready && !flush;

    // -----------------------------------------------------------------------
    // Queue control state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Accepted-request counter, internal only; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accept_cnt <= '0;
        end else if (handshake_in) begin
            accept_cnt <= accept_cnt + 16'd1;
        end
    end

    // Payload storage needs no reset: it is masked whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_target[wr_ptr] <= target;
            mem_link[wr_ptr]   <= seq_pc;
            mem_mis[wr_ptr]    <= target_misaligned;
        end
    end

    // -----------------------------------------------------------------------
    // Head outputs, forced to zero while the queue is empty
    // -----------------------------------------------------------------------
    always_comb begin
        branch_PC  = '0;
        link_PC    = '0;
        misaligned = 1'b0;
        if (out_valid) begin
            branch_PC  = mem_target[rd_ptr];
            link_PC    = mem_link[rd_ptr];
            misaligned = mem_mis[rd_ptr];
        end
    end

    // -----------------------------------------------------------------------
    // Assertions
    // -----------------------------------------------------------------------
    a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
        count <= CNT_W'(DEPTH));

    a_accept_cnt : assert property (@(posedge clk) disable iff (!rst_n)
        handshake_in |=> (accept_cnt == $past(accept_cnt) + 16'd1));

endmodule

// File: tb/tb_branch_target_unit.sv
module tb_branch_target_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      mode = 2'b00;
    logic [XLEN-1:0] current_PC = '0;
    logic [XLEN-1:0] imm_value = '0;
    logic [XLEN-1:0] rs1_value = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] branch_PC;
    logic [XLEN-1:0] link_PC;
    logic            misaligned;

    branch_target_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .current_PC (current_PC),
        .imm_value  (imm_value),
        .rs1_value  (rs1_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .branch_PC  (branch_PC),
        .link_PC    (link_PC),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] tgt;
        logic [31:0] link;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    exp_t cur_exp;
    exp_t head_exp;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic mis_of(input logic [31:0] t);
`ifdef BTU_RVC_EN
        return t[0];
`else
        return |t[1:0];
`endif
    endfunction

    task automatic drive(input logic [1:0] m, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] tgt, input logic [31:0] link);
        mode       = m;
        current_PC = pc;
        imm_value  = imm;
        rs1_value  = rs1;
        cur_exp    = '{tgt: tgt, link: link, mis: mis_of(tgt)};
        in_valid   = 1'b1;
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("accept", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] m, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic [31:0] tgt, input logic [31:0] link);
        drive(m, pc, imm, rs1, tgt, link);
        wait_accept();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare on every output handshake, then record
    // any request accepted in this cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_entry: got branch_PC=%0h expected no entry", branch_PC);
                end else begin
                    head_exp = sb.pop_front();
                    chk("branch_PC", {32'b0, branch_PC}, {32'b0, head_exp.tgt});
                    chk("link_PC",   {32'b0, link_PC},   {32'b0, head_exp.link});
                    chk("misaligned", {63'b0, misaligned}, {63'b0, head_exp.mis});
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    initial begin
        // Reset state
        out_ready = 1'b1;
        idle(2);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_branch_PC", {32'b0, branch_PC}, 64'd0);
        chk("rst_link_PC",   {32'b0, link_PC},   64'd0);
        chk("rst_misaligned", {63'b0, misaligned}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

        // Basic targets, one-cycle latency
        send(2'b00, 32'h0000_1000, 32'hFFFF_FFF0, 32'h0, 32'h0000_0FF0, 32'h0000_1004);
        chk("latency_out_valid", {63'b0, out_valid}, 64'd1);
        send(2'b10, 32'h0000_3000, 32'h0000_0000, 32'h0000_2003, 32'h0000_2002, 32'h0000_3004);
        send(2'b01, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0, 32'h0000_0004, 32'h0000_0000);
        send(2'b11, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0, 32'h0000_0000, 32'h0000_0000);
        send(2'b00, 32'h0000_0100, 32'h0000_0002, 32'h0, 32'h0000_0102, 32'h0000_0104);
        send(2'b10, 32'h0000_0200, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000E, 32'h0000_0204);
        idle(3);

        // Back-pressure: third request stalls until the first pop
        out_ready = 1'b0;
        drive(2'b00, 32'h0000_4000, 32'h0000_0010, 32'h0, 32'h0000_4010, 32'h0000_4004);
        idle(1);
        drive(2'b01, 32'h0000_5000, 32'h0000_0100, 32'h0, 32'h0000_5100, 32'h0000_5004);
        idle(1);
        drive(2'b11, 32'h0000_6000, 32'h0000_0000, 32'h0, 32'h0000_6004, 32'h0000_6004);
        @(negedge clk);
        chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
        idle(1);
        chk("stall_in_ready2", {63'b0, in_ready}, 64'd0);
        chk("stall_head_stable", {32'b0, branch_PC}, 64'h4010);
        out_ready = 1'b1;
        #1;
        chk("pop_frees_slot", {63'b0, in_ready}, 64'd1);
        idle(1);
        in_valid = 1'b0;
        idle(4);

        // Flush with a concurrent request: the request is dropped
        out_ready = 1'b0;
        send(2'b00, 32'h0000_7000, 32'h0000_0020, 32'h0, 32'h0000_7020, 32'h0000_7004);
        send(2'b00, 32'h0000_8000, 32'h0000_0040, 32'h0, 32'h0000_8040, 32'h0000_8004);
        drive(2'b01, 32'h0000_9000, 32'h0000_0044, 32'h0, 32'h0000_9044, 32'h0000_9004);
        flush     = 1'b1;
        out_ready = 1'b1;
        idle(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
        idle(4);

        // Asynchronous reset mid-stream with two entries queued
        out_ready = 1'b0;
        send(2'b00, 32'h0000_A000, 32'h0000_0008, 32'h0, 32'h0000_A008, 32'h0000_A004);
        send(2'b10, 32'h0000_B000, 32'h0000_0001, 32'h0000_0101, 32'h0000_0102, 32'h0000_B004);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("arst_branch_PC", {32'b0, branch_PC}, 64'd0);
        chk("arst_link_PC",   {32'b0, link_PC},   64'd0);
        chk("arst_misaligned", {63'b0, misaligned}, 64'd0);
        idle(2);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(4);
        chk("post_reset_out_valid", {63'b0, out_valid}, 64'd0);
        send(2'b01, 32'h0000_C000, 32'h0000_0010, 32'h0, 32'h0000_C010, 32'h0000_C004);
        idle(4);

        chk("drain", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
